// File: rtl/clk_trim_pkg.sv
// Shared types and helpers for the multi-channel clock trimmer.
//   trim_st_t   : per-channel mode (IDLE, nominal RUN, advancing, retarding)
//   L_NOM/L_ADV/L_RET : period lengths for the default 240->24 MHz ratio
//   period_len(): period length for any DIV, given mode and slip flag
package clk_trim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ADV, RET} trim_st_t;

  localparam int DIV_NOM = 10;
  localparam int L_NOM   = DIV_NOM;
  localparam int L_ADV   = DIV_NOM - 1;
  localparam int L_RET   = DIV_NOM + 1;

  // Only slip periods deviate from DIV; the low phase absorbs the +/-1.
  function automatic int period_len(input trim_st_t st, input logic slip, input int div);
    if (slip && st == ADV) return div - 1;
    if (slip && st == RET) return div + 1;
    return div;
  endfunction

endpackage

// File: rtl/clk_trim_ch.sv
// One trimmed output clock channel.
//   clk, reset_n      : system clock / async active-low reset
//   en_i              : run enable, sampled in IDLE and at period end
//   adv_i, ret_i      : trim requests, sampled at period end only
//   clk_out_o         : divided clock, straight from a flop
//   slip_pulse_o      : high on the last cycle of a slipped period
//   active_o          : channel not in IDLE (feeds the top-level busy flop)
module clk_trim_ch
  import clk_trim_pkg::*;
#(
  parameter int DIV        = 10,
  parameter int SLIP_EVERY = 10,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic adv_i,
  input  logic ret_i,
  output logic clk_out_o,
  output logic slip_pulse_o,
  output logic active_o
);

  localparam int PW = (SLIP_EVERY > 1) ? $clog2(SLIP_EVERY) : 1;
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(DIV / 2);
  localparam logic [PW-1:0]    PLAST = PW'(SLIP_EVERY - 1);

  trim_st_t         st_q, st_d, want;
  logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             clk_q, clk_d, slip_q, slip_d, slip_per;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      pcnt_q <= '0;
      clk_q  <= 1'b0;
      slip_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      clk_q  <= clk_d;
      slip_q <= slip_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    pcnt_d = pcnt_q;
    clk_d  = 1'b0;
    slip_d = 1'b0;
    // pcnt is frozen within a period, so the slip decision holds for the whole period
    slip_per = (st_q == ADV || st_q == RET) && (pcnt_q == PLAST);
    last_cnt = CNT_W'(period_len(st_q, slip_per, DIV) - 1);
    want = RUN;
    if (adv_i && !ret_i)      want = ADV;
    else if (ret_i && !adv_i) want = RET;

    if (st_q == IDLE) begin
      cnt_d  = '0;
      pcnt_d = '0;
      if (en_i) begin
        st_d  = RUN;
        clk_d = 1'b1;
      end
    end else if (cnt_q == last_cnt) begin
      cnt_d = '0;
      if (!en_i) begin
        st_d   = IDLE;
        pcnt_d = '0;
      end else begin
        st_d  = want;
        clk_d = 1'b1;
        if (want == RUN || want != st_q) pcnt_d = '0;
        else if (slip_per)               pcnt_d = '0;
        else                             pcnt_d = pcnt_q + 1'b1;
      end
    end else begin
      cnt_d  = cnt_q + 1'b1;
      clk_d  = (cnt_d < HALF);
      // last_cnt >= 2, so the pulse cycle is never the first of a period
      slip_d = slip_per && (cnt_d == last_cnt);
    end
  end

  assign clk_out_o    = clk_q;
  assign slip_pulse_o = slip_q;
  assign active_o     = (st_q != IDLE);

endmodule

// File: rtl/multi_clk_trim.sv
// NUM_CH independent divided sensor clocks with per-channel phase trim.
//   clk, reset_n        : system clock / async active-low reset
//   en[NUM_CH]          : per-channel run enable
//   err_adv/err_ret     : per-channel advance / retard requests (level)
//   clk_out[NUM_CH]     : divided clocks, each from a flop
//   slip_pulse[NUM_CH]  : one-cycle pulse closing each slipped period
//   busy                : registered OR of all channels not in IDLE
module multi_clk_trim #(
  parameter int NUM_CH     = 2,
  parameter int DIV        = 10,
  parameter int SLIP_EVERY = 10,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] err_adv,
  input  logic [NUM_CH-1:0] err_ret,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] slip_pulse,
  output logic              busy
);

  logic [NUM_CH-1:0] active;
  logic              busy_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_trim_ch #(
      .DIV       (DIV),
      .SLIP_EVERY(SLIP_EVERY),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_i        (en[g]),
      .adv_i       (err_adv[g]),
      .ret_i       (err_ret[g]),
      .clk_out_o   (clk_out[g]),
      .slip_pulse_o(slip_pulse[g]),
      .active_o    (active[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= 1'b0;
    else          busy_q <= |active;
  end

  assign busy = busy_q;

endmodule
